// File: rtl/nios_cpu_div_cell_if.sv
// Operand/handshake bundle between the Nios M-stage and the iterative divider.
// master = CPU side, slave = divider side.
interface nios_cpu_div_cell_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] M_div_src1;
  logic [DATA_W-1:0] M_div_src2;
  logic              M_div_signed;
  logic              M_div_start;
  logic              M_div_kill;
  logic              M_div_busy;
  logic              M_div_done;
  logic [DATA_W-1:0] M_div_quot;
  logic [DATA_W-1:0] M_div_rem;
  logic              M_div_dbz;

  modport master (
    output M_div_src1, M_div_src2, M_div_signed, M_div_start, M_div_kill,
    input  M_div_busy, M_div_done, M_div_quot, M_div_rem, M_div_dbz
  );

  modport slave (
    input  M_div_src1, M_div_src2, M_div_signed, M_div_start, M_div_kill,
    output M_div_busy, M_div_done, M_div_quot, M_div_rem, M_div_dbz
  );
endinterface

// File: rtl/nios_cpu_div_cell.sv
// Iterative restoring radix-2 divider (div/divu) for the Nios M-stage, one quotient bit per clock.
// Optional NIOS_CPU_DIV_EARLY_OUT_EN: skip the iteration when divisor is zero or exceeds the dividend.
module nios_cpu_div_cell #(
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] DBZ_QUOT = {DATA_W{1'b1}}
) (
  input logic                  clk,
  input logic                  reset,
  nios_cpu_div_cell_if.slave   div_if
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIV, S_FIX, S_DONE} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] dvd, dvs, rem_p, src1_orig;
  logic [DATA_W-1:0] quot_q, rem_q;
  logic              sgn, neg_q, neg_r, dbz, dbz_q;
  logic [CNT_W-1:0]  count;

  logic [DATA_W-1:0] dvd_mag, dvs_mag, quot_fix, rem_fix;
  logic [DATA_W:0]   trial;
  logic              qbit, early_out, accept;

  assign accept = div_if.M_div_start && !div_if.M_div_kill;

  always_comb begin
    dvd_mag  = (sgn && dvd[DATA_W-1]) ? -dvd : dvd;
    dvs_mag  = (sgn && dvs[DATA_W-1]) ? -dvs : dvs;
    // Quotient bits shift into dvd from the right, so after DATA_W steps dvd holds the quotient.
    trial    = {rem_p, dvd[DATA_W-1]};
    qbit     = (trial >= {1'b0, dvs});
`ifdef NIOS_CPU_DIV_EARLY_OUT_EN
    early_out = (dvs == '0) || (dvs_mag > dvd_mag);
`else
    early_out = 1'b0;
`endif
    quot_fix = neg_q ? -dvd : dvd;
    rem_fix  = neg_r ? -rem_p : rem_p;
    if (dbz) begin
      quot_fix = DBZ_QUOT;
      rem_fix  = src1_orig;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_PREP;
      S_PREP:  state_nx = early_out ? S_FIX : S_DIV;
      S_DIV:   if (count == '0) state_nx = S_FIX;
      S_FIX:   state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (div_if.M_div_kill && state != S_IDLE) state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd       <= '0;
      dvs       <= '0;
      rem_p     <= '0;
      src1_orig <= '0;
      sgn       <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dbz       <= 1'b0;
      count     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          dvd       <= div_if.M_div_src1;
          dvs       <= div_if.M_div_src2;
          src1_orig <= div_if.M_div_src1;
          sgn       <= div_if.M_div_signed;
          neg_q     <= div_if.M_div_signed &
                       (div_if.M_div_src1[DATA_W-1] ^ div_if.M_div_src2[DATA_W-1]);
          neg_r     <= div_if.M_div_signed & div_if.M_div_src1[DATA_W-1];
        end
        S_PREP: begin
          dvs   <= dvs_mag;
          dbz   <= (dvs == '0);
          count <= CNT_W'(DATA_W - 1);
          if (early_out) begin
            rem_p <= dvd_mag;
            dvd   <= '0;
          end else begin
            rem_p <= '0;
            dvd   <= dvd_mag;
          end
        end
        S_DIV: begin
          rem_p <= qbit ? (trial[DATA_W-1:0] - dvs) : trial[DATA_W-1:0];
          dvd   <= {dvd[DATA_W-2:0], qbit};
          count <= count - CNT_W'(1);
        end
        S_FIX: if (!div_if.M_div_kill) begin
          quot_q <= quot_fix;
          rem_q  <= rem_fix;
          dbz_q  <= dbz;
        end
        default: ;
      endcase
    end
  end

  assign div_if.M_div_busy = (state == S_PREP) || (state == S_DIV) || (state == S_FIX);
  assign div_if.M_div_done = (state == S_DONE);
  assign div_if.M_div_quot = quot_q;
  assign div_if.M_div_rem  = rem_q;
  assign div_if.M_div_dbz  = dbz_q;

endmodule
